decode_regfile_fwd: RTL and testbench

Parametrised register-read block for the decode stage. It holds a NREGS x DATA_W register file with write-to-read bypass and an exception PC (EPC) register. It has two read ports, each fed through a NUM_FWD-deep forwarding network with youngest-first priority. It also detects load-use hazards (a matching forward entry whose data is not yet ready) and raises a stall, and counts stall cycles in a saturating performance counter.

---
 rtl/decode_regfile_fwd.sv | 93 +++++++++
 tb/tb_decode_regfile_fwd.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile_fwd.sv
// decode_regfile_fwd: decode-stage register read with youngest-first forwarding, load-use stall and EPC
// Ports: clk/rst (async active-low); rd1_*/rd2_* read selects and consume enables;
//        wr_* writeback; fwd_* packed forwarding entries (index 0 youngest);
//        epc_capture/epc_data/epc_read EPC access; stall_clr clears the stall counter;
//        rd1_data/rd2_data operands, epc, stall, stall_count (saturating), err (illegal select).
module decode_regfile_fwd #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int NUM_FWD  = 3,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW-1:0]             rd1_sel,
    input  logic                      rd1_en,
    input  logic [AW-1:0]             rd2_sel,
    input  logic                      rd2_en,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_sel,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [NUM_FWD*AW-1:0]     fwd_sel,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      epc_capture,
    input  logic [DATA_W-1:0]         epc_data,
    input  logic                      epc_read,
    input  logic                      stall_clr,
    output logic [DATA_W-1:0]         rd1_data,
    output logic [DATA_W-1:0]         rd2_data,
    output logic [DATA_W-1:0]         epc,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_count,
    output logic                      err
);
    localparam logic [AW:0] NR = (AW + 1)'(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] d1, d2;
    logic              hz1, hz2, wr_ok;

    function automatic logic in_range(input logic [AW-1:0] s);
        return {1'b0, s} < NR;
    endfunction

    // Returns {hazard, data}; the descending scan lets the youngest matching entry win.
    function automatic logic [DATA_W:0] lookup(input logic [AW-1:0] s);
        logic [DATA_W:0] r;
        r = {1'b0, (wr_ok && wr_sel == s) ? wr_data : regs[s]};
        for (int i = NUM_FWD - 1; i >= 0; i--)
            if (fwd_valid[i] && fwd_sel[i*AW +: AW] == s)
                r = {~fwd_ready[i], fwd_data[i*DATA_W +: DATA_W]};
        if (!in_range(s) || (ZERO_REG != 0 && s == '0))
            r = '0;
        return r;
    endfunction

    assign wr_ok = wr_en && in_range(wr_sel) && !(ZERO_REG != 0 && wr_sel == '0);

    always_comb begin
        {hz1, d1} = lookup(rd1_sel);
        {hz2, d2} = lookup(rd2_sel);
    end

    assign rd1_data = epc_read ? epc : d1;
    assign rd2_data = d2;
    assign stall    = (rd1_en && hz1 && !epc_read) || (rd2_en && hz2);
    assign err      = (wr_en && !in_range(wr_sel)) ||
                      (rd1_en && !epc_read && !in_range(rd1_sel)) ||
                      (rd2_en && !in_range(rd2_sel));

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (wr_ok)
            regs[wr_sel] <= wr_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            epc <= '0;
        else if (epc_capture)
            epc <= epc_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            stall_count <= '0;
        else if (stall_clr)
            stall_count <= '0;
        else if (stall && !(&stall_count))
            stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_decode_regfile_fwd.sv
// tb_decode_regfile_fwd: directed bench driving a default instance (a) and a small-config instance (b)
module tb_decode_regfile_fwd;
    logic        clk = 0;
    logic        rst;
    logic [2:0]  rd1_sel, rd2_sel, wr_sel;
    logic        rd1_en, rd2_en, wr_en;
    logic [15:0] wr_data, epc_data;
    logic [2:0]  fwd_valid, fwd_ready;
    logic [8:0]  fwd_sel;
    logic [47:0] fwd_data;
    logic        epc_capture, epc_read, stall_clr;
    logic [15:0] rd1_a, rd2_a, epc_a, cnt_a, rd1_b, rd2_b, epc_b;
    logic [3:0]  cnt_b;
    logic        stall_a, err_a, stall_b, err_b;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    decode_regfile_fwd u_a (
        .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd1_en(rd1_en), .rd2_sel(rd2_sel), .rd2_en(rd2_en),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .epc_capture(epc_capture), .epc_data(epc_data),
        .epc_read(epc_read), .stall_clr(stall_clr), .rd1_data(rd1_a), .rd2_data(rd2_a), .epc(epc_a),
        .stall(stall_a), .stall_count(cnt_a), .err(err_a)
    );

    decode_regfile_fwd #(.NREGS(6), .ZERO_REG(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd1_en(rd1_en), .rd2_sel(rd2_sel), .rd2_en(rd2_en),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .epc_capture(epc_capture), .epc_data(epc_data),
        .epc_read(epc_read), .stall_clr(stall_clr), .rd1_data(rd1_b), .rd2_data(rd2_b), .epc(epc_b),
        .stall(stall_b), .stall_count(cnt_b), .err(err_b)
    );

    task automatic idle();
        rd1_sel = 0; rd1_en = 0; rd2_sel = 0; rd2_en = 0;
        wr_en = 0; wr_sel = 0; wr_data = 0;
        fwd_valid = 0; fwd_ready = 0; fwd_sel = 0; fwd_data = 0;
        epc_capture = 0; epc_data = 0; epc_read = 0; stall_clr = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        rd1_sel = 3; rd2_sel = 5;
        #1;
        checks++; if (rd1_a !== 16'h0) begin fails++; $display("FAIL reset_rd1: got %h expected 0000", rd1_a); end
        checks++; if (epc_a !== 16'h0) begin fails++; $display("FAIL reset_epc: got %h expected 0000", epc_a); end
        checks++; if (cnt_a !== 16'h0 || cnt_b !== 4'h0) begin fails++; $display("FAIL reset_cnt: got %h/%h expected 0/0", cnt_a, cnt_b); end
        checks++; if (stall_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL reset_flags: stall=%b err=%b expected 0 0", stall_a, err_a); end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_write_read();
        @(negedge clk); wr_en = 1; wr_sel = 3; wr_data = 16'h1234;
        @(negedge clk); wr_en = 0; rd1_sel = 3; rd1_en = 1;
        #1;
        checks++; if (rd1_a !== 16'h1234) begin fails++; $display("FAIL wr_rd: got %h expected 1234", rd1_a); end
        @(negedge clk); wr_en = 1; wr_sel = 5; wr_data = 16'hBEEF; rd2_sel = 5; rd2_en = 1;
        #1;
        checks++; if (rd2_a !== 16'hBEEF) begin fails++; $display("FAIL bypass: got %h expected beef", rd2_a); end
        @(negedge clk); wr_en = 0;
        #1;
        checks++; if (rd2_a !== 16'hBEEF || rd2_b !== 16'hBEEF) begin fails++; $display("FAIL bypass_commit: got %h/%h expected beef", rd2_a, rd2_b); end
        idle();
    endtask

    task automatic test_forward();
        @(negedge clk); wr_en = 1; wr_sel = 2; wr_data = 16'h1111;
        @(negedge clk); wr_en = 0;
        fwd_valid = 3'b111; fwd_ready = 3'b111; fwd_sel = {3'd2, 3'd2, 3'd2};
        fwd_data = {16'hCCCC, 16'hBBBB, 16'hAAAA}; rd2_sel = 2; rd2_en = 1;
        #1;
        checks++; if (rd2_a !== 16'hAAAA) begin fails++; $display("FAIL fwd_youngest: got %h expected aaaa", rd2_a); end
        checks++; if (stall_a !== 1'b0) begin fails++; $display("FAIL fwd_nostall: got %b expected 0", stall_a); end
        fwd_valid = 3'b110; #1;
        checks++; if (rd2_a !== 16'hBBBB) begin fails++; $display("FAIL fwd_entry1: got %h expected bbbb", rd2_a); end
        fwd_valid = 3'b100; #1;
        checks++; if (rd2_a !== 16'hCCCC) begin fails++; $display("FAIL fwd_entry2: got %h expected cccc", rd2_a); end
        fwd_valid = 3'b111; fwd_sel = {3'd2, 3'd2, 3'd3}; #1;
        checks++; if (rd2_a !== 16'hBBBB) begin fails++; $display("FAIL fwd_selmiss: got %h expected bbbb", rd2_a); end
        fwd_valid = 3'b000; #1;
        checks++; if (rd2_a !== 16'h1111) begin fails++; $display("FAIL fwd_none: got %h expected 1111", rd2_a); end
        idle();
    endtask

    task automatic test_load_use();
        @(negedge clk); stall_clr = 1;
        @(negedge clk); stall_clr = 0;
        fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_sel = {3'd0, 3'd0, 3'd4}; rd1_sel = 4; rd1_en = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (stall_a !== 1'b1) begin fails++; $display("FAIL load_use_stall%0d: got %b expected 1", k, stall_a); end
            @(negedge clk);
        end
        checks++; if (cnt_a !== 16'd3) begin fails++; $display("FAIL load_use_cnt: got %0d expected 3", cnt_a); end
        rd1_en = 0; #1;
        checks++; if (stall_a !== 1'b0) begin fails++; $display("FAIL load_use_noen: got %b expected 0", stall_a); end
        rd1_en = 1; epc_read = 1; #1;
        checks++; if (stall_a !== 1'b0) begin fails++; $display("FAIL load_use_epcread: got %b expected 0", stall_a); end
        epc_read = 0; rd1_en = 0; rd2_sel = 4; rd2_en = 1;
        fwd_valid = 3'b011; fwd_ready = 3'b010; fwd_sel = {3'd0, 3'd4, 3'd4}; #1;
        checks++; if (stall_a !== 1'b1) begin fails++; $display("FAIL load_use_youngest: got %b expected 1", stall_a); end
        fwd_ready = 3'b001; fwd_data = {16'h0, 16'h2222, 16'h3333}; #1;
        checks++; if (stall_a !== 1'b0 || rd2_a !== 16'h3333) begin fails++; $display("FAIL load_use_ready: stall=%b data=%h expected 0 3333", stall_a, rd2_a); end
        idle();
    endtask

    task automatic test_epc();
        @(negedge clk); epc_capture = 1; epc_data = 16'h0042;
        @(negedge clk); epc_capture = 0; epc_read = 1; rd1_sel = 3; rd1_en = 1;
        #1;
        checks++; if (rd1_a !== 16'h0042 || epc_a !== 16'h0042) begin fails++; $display("FAIL epc_read: got %h/%h expected 0042", rd1_a, epc_a); end
        @(negedge clk); epc_capture = 1; epc_data = 16'h0099;
        #1;
        checks++; if (rd1_a !== 16'h0042) begin fails++; $display("FAIL epc_old: got %h expected 0042", rd1_a); end
        @(negedge clk); epc_capture = 0; rd1_sel = 7;
        #1;
        checks++; if (rd1_a !== 16'h0099) begin fails++; $display("FAIL epc_new: got %h expected 0099", rd1_a); end
        checks++; if (err_b !== 1'b0) begin fails++; $display("FAIL epc_err_mask: got %b expected 0", err_b); end
        epc_read = 0; #1;
        checks++; if (err_b !== 1'b1 || rd1_b !== 16'h0) begin fails++; $display("FAIL rd_oob: err=%b data=%h expected 1 0000", err_b, rd1_b); end
        idle();
    endtask

    task automatic test_zero_reg();
        @(negedge clk); wr_en = 1; wr_sel = 0; wr_data = 16'hFFFF; rd1_sel = 0; rd1_en = 1;
        #1;
        checks++; if (rd1_b !== 16'h0 || rd1_a !== 16'hFFFF) begin fails++; $display("FAIL zero_bypass: got %h/%h expected 0000/ffff", rd1_b, rd1_a); end
        @(negedge clk); wr_en = 0;
        #1;
        checks++; if (rd1_b !== 16'h0 || rd1_a !== 16'hFFFF) begin fails++; $display("FAIL zero_read: got %h/%h expected 0000/ffff", rd1_b, rd1_a); end
        fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_sel = 9'd0; fwd_data = 48'h5555; #1;
        checks++; if (stall_b !== 1'b0 || rd1_b !== 16'h0 || stall_a !== 1'b1) begin fails++; $display("FAIL zero_fwd: stall_b=%b rd1_b=%h stall_a=%b expected 0 0000 1", stall_b, rd1_b, stall_a); end
        idle();
        @(negedge clk); wr_en = 1; wr_sel = 7; wr_data = 16'h7777;
        #1;
        checks++; if (err_b !== 1'b1 || err_a !== 1'b0) begin fails++; $display("FAIL wr_oob_err: got %b/%b expected 1/0", err_b, err_a); end
        @(negedge clk); wr_en = 0; rd1_sel = 3; rd2_sel = 5;
        #1;
        checks++; if (rd1_b !== 16'h1234 || rd2_b !== 16'hBEEF) begin fails++; $display("FAIL wr_oob_nochange: got %h/%h expected 1234/beef", rd1_b, rd2_b); end
        rd1_sel = 7; #1;
        checks++; if (rd1_b !== 16'h0 || rd1_a !== 16'h7777) begin fails++; $display("FAIL wr_oob_r7: got %h/%h expected 0000/7777", rd1_b, rd1_a); end
        @(negedge clk); wr_en = 1; wr_sel = 3; wr_data = 16'hAAAA;
        #2; rst = 0;
        @(negedge clk); wr_en = 0; rd1_sel = 3; rd2_sel = 5;
        #1;
        checks++; if (rd1_a !== 16'h0 || rd2_a !== 16'h0 || rd1_b !== 16'h0 || epc_a !== 16'h0) begin fails++; $display("FAIL rst_midwrite: got %h %h %h %h expected all 0000", rd1_a, rd2_a, rd1_b, epc_a); end
        @(negedge clk); rst = 1;
        @(negedge clk);
        checks++; if (rd1_a !== 16'h0) begin fails++; $display("FAIL rst_dropwrite: got %h expected 0000", rd1_a); end
        idle();
    endtask

    task automatic test_saturate();
        @(negedge clk); stall_clr = 1;
        @(negedge clk); stall_clr = 0;
        fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_sel = {3'd0, 3'd0, 3'd4}; rd1_sel = 4; rd1_en = 1;
        repeat (20) @(negedge clk);
        checks++; if (cnt_b !== 4'd15 || cnt_a !== 16'd20) begin fails++; $display("FAIL sat_cnt: got %0d/%0d expected 15/20", cnt_b, cnt_a); end
        @(negedge clk);
        checks++; if (cnt_b !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d expected 15", cnt_b); end
        stall_clr = 1;
        @(negedge clk); stall_clr = 0;
        checks++; if (cnt_b !== 4'd0 || cnt_a !== 16'd0) begin fails++; $display("FAIL sat_clr: got %0d/%0d expected 0/0", cnt_b, cnt_a); end
        @(negedge clk);
        checks++; if (cnt_b !== 4'd1 || cnt_a !== 16'd1) begin fails++; $display("FAIL sat_restart: got %0d/%0d expected 1/1", cnt_b, cnt_a); end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_load_use();
        test_epc();
        test_zero_reg();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
